gnr_attractor_sched: RTL and testbench
======================================

Name: gnr_attractor_sched

Overview:
- Sequencer for a bank of N_NODES Boolean-network node cells. Each cell holds a half-rate copy s0 (the tortoise) and a full-rate copy s1 (the hare), and is controlled by reset_nos, start_s0, start_s1 and init_state.
- Loads an initial state vector into all nodes, then steps them until s0 == s1 (Floyd meet). Optionally it then measures the attractor period.
- Sits between the host command/status interface and the node array. It is the only driver of the node control strobes.

Parameters:
- N_NODES, 188, number of node cells; width of the state and init vectors.
- CNT_W, 16, width of the step and period counters.
- MAX_STEPS, 16'hFFFF, step limit in RUN; reaching it aborts with timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  run request; sampled only in IDLE.
- init_vec  in  N_NODES  initial state; captured when start is accepted.
- s0_vec  in  N_NODES  concatenated s0 outputs of the node cells.
- s1_vec  in  N_NODES  concatenated s1 outputs of the node cells.
- reset_nos  out  1  node load strobe.
- start_s0  out  1  s0 step strobe.
- start_s1  out  1  s1 step strobe.
- init_state  out  N_NODES  per-node init value; bit i goes to node i.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE; stays high until the next accepted start.
- timeout  out  1  valid with done; 1 = MAX_STEPS reached without a meet.
- meet_steps  out  CNT_W  step count at which the meet occurred.
- period  out  CNT_W  attractor period; 0 if timeout.
- attractor  out  N_NODES  s0_vec captured at the meet.

Behaviour:
- Node contract:
  - reset_nos loads init_state into s0 and s1, and arms s0 to update on its next start_s0.
  - With start_s0 held every cycle, s0 updates on alternate strobes; s1 updates on every start_s1.
  - After k joint steps, s1 = f^k(x) and s0 = f^ceil(k/2)(x).
- Reset (rst=0 at posedge): state IDLE.
  - All strobes 0; busy, done and timeout 0.
  - meet_steps, period and attractor 0; init_state 0; counters 0.
- IDLE: start=1 latches init_vec into init_state, clears step_cnt, period_cnt and done, then goes to LOAD.
- LOAD (exactly 1 cycle): reset_nos=1, other strobes 0. Next state RUN.
- RUN, each cycle:
  - If step_cnt >= 2 and s0_vec == s1_vec: meet.
    - Strobes 0 this cycle; capture meet_steps = step_cnt and attractor = s0_vec.
    - Go to PERIOD, or to DONE when the feature is off.
  - Else if step_cnt == MAX_STEPS: timeout=1, period=0, go to DONE.
  - Else: start_s0 = start_s1 = 1 and step_cnt increments.
- RUN compare gate: step_cnt < 2 is never compared, because s0 == s1 trivially at k = 0 and k = 1.
- Meet priority: a meet at step_cnt == MAX_STEPS wins over timeout.
- PERIOD, each cycle:
  - start_s0 = 0 (s0 frozen on the attractor).
  - If period_cnt >= 1 and s1_vec == attractor: period = period_cnt, go to DONE.
  - Else: start_s1 = 1 and period_cnt increments.
  - If period_cnt reaches all-ones: timeout = 1 and go to DONE.
- DONE: strobes 0; done = 1.
  - start=1 restarts directly into LOAD with a new init_vec.
- start outside IDLE/DONE is ignored.
- Strobe timing: strobes are combinational from state and registered counters, and change only on posedge-registered state.
- Reset mid-operation: rst=0 aborts at the next edge; no strobe is asserted during the reset cycle.

Optional Feature:
- Macro GNR_PERIOD_MEASURE_EN.
- Defined: the PERIOD state exists and period is reported as above.
- Undefined:
  - No PERIOD state; a meet goes straight to DONE.
  - period is tied to 0 and the period counter is not synthesised.

Test Plan:
- Fixed point: f = identity, N=3, init 3'b101 → LOAD 1 cycle; 2 step cycles; meet_steps=2, attractor=101, period=1, timeout=0, done 1.
- Rotate-3 oscillator (x_i' = x_{i-1}), init 3'b001 → meet_steps=6, attractor=3'b001, period=3; start_s0 stays 0 during the 3 PERIOD strobes.
- Timeout: rotate-3 with MAX_STEPS=4, init 001 and an s0 path forced never to match → after 4 steps done=1, timeout=1, period=0.
- Reset mid-RUN: rst=0 at step 3 → next cycle IDLE with all outputs 0; a fresh start reproduces the full result.
- Start while busy: pulse start during RUN → ignored. Restart from DONE with init 3'b010 → LOAD shows init_state=010, done drops, new results are reported.
- Feature off: rotate-3 with the macro undefined → done after meet_steps=6 with period=0 and no PERIOD cycles.

Source files
------------

// File: rtl/gnr_attractor_sched.sv
// Floyd tortoise/hare sequencer for a bank of Boolean-network node cells.
// Define GNR_PERIOD_MEASURE_EN to add the PERIOD state that measures the attractor period.
module gnr_attractor_sched #(
    parameter int                N_NODES   = 188,
    parameter int                CNT_W     = 16,
    parameter logic [CNT_W-1:0]  MAX_STEPS = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PERIOD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] step_cnt;
    logic             accept, step_inc, capture_meet, run_timeout;

`ifdef GNR_PERIOD_MEASURE_EN
    logic [CNT_W-1:0] period_cnt;
    logic             per_inc, per_hit, per_timeout;
`else
    assign period = '0;
`endif

    always_comb begin
        state_next   = state;
        reset_nos    = 1'b0;
        start_s0     = 1'b0;
        start_s1     = 1'b0;
        accept       = 1'b0;
        step_inc     = 1'b0;
        capture_meet = 1'b0;
        run_timeout  = 1'b0;
`ifdef GNR_PERIOD_MEASURE_EN
        per_inc      = 1'b0;
        per_hit      = 1'b0;
        per_timeout  = 1'b0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                reset_nos  = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                // At k = 0 and k = 1 the copies agree trivially, so compare only from k = 2.
                if (step_cnt >= CNT_W'(2) && s0_vec == s1_vec) begin
                    capture_meet = 1'b1;
`ifdef GNR_PERIOD_MEASURE_EN
                    state_next   = S_PERIOD;
`else
                    state_next   = S_DONE;
`endif
                end else if (step_cnt == MAX_STEPS) begin
                    run_timeout = 1'b1;
                    state_next  = S_DONE;
                end else begin
                    start_s0 = 1'b1;
                    start_s1 = 1'b1;
                    step_inc = 1'b1;
                end
            end
`ifdef GNR_PERIOD_MEASURE_EN
            S_PERIOD: begin
                // s0 stays parked on the attractor while s1 walks around the cycle.
                if (period_cnt != '0 && s1_vec == attractor) begin
                    per_hit    = 1'b1;
                    state_next = S_DONE;
                end else if (period_cnt == '1) begin
                    per_timeout = 1'b1;
                    state_next  = S_DONE;
                end else begin
                    start_s1 = 1'b1;
                    per_inc  = 1'b1;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
        if (!rst) begin
            reset_nos = 1'b0;
            start_s0  = 1'b0;
            start_s1  = 1'b0;
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            step_cnt   <= '0;
            init_state <= '0;
            timeout    <= 1'b0;
            meet_steps <= '0;
            attractor  <= '0;
`ifdef GNR_PERIOD_MEASURE_EN
            period_cnt <= '0;
            period     <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                init_state <= init_vec;
                step_cnt   <= '0;
                timeout    <= 1'b0;
                meet_steps <= '0;
                attractor  <= '0;
`ifdef GNR_PERIOD_MEASURE_EN
                period_cnt <= '0;
                period     <= '0;
`endif
            end
            if (step_inc)
                step_cnt <= step_cnt + 1'b1;
            if (capture_meet) begin
                meet_steps <= step_cnt;
                attractor  <= s0_vec;
            end
            if (run_timeout)
                timeout <= 1'b1;
`ifdef GNR_PERIOD_MEASURE_EN
            if (per_inc)
                period_cnt <= period_cnt + 1'b1;
            if (per_hit)
                period <= period_cnt;
            if (per_timeout) begin
                timeout <= 1'b1;
                period  <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gnr_attractor_sched.sv
// Bench for gnr_attractor_sched: table-driven node-array model plus an orbit-based reference.
module tb_gnr_attractor_sched;

    localparam int          N    = 4;
    localparam int          CW   = 16;
    localparam logic [15:0] MAXS = 16'd40;
`ifdef GNR_PERIOD_MEASURE_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  init_vec = '0;
    logic [N-1:0]  s0_vec, s1_vec;
    logic          reset_nos, start_s0, start_s1, busy, done, timeout;
    logic [N-1:0]  init_state, attractor;
    logic [CW-1:0] meet_steps, period;

    logic [N-1:0]  ftab [16];
    logic [N-1:0]  s0_q = '0;
    logic [N-1:0]  s1_q = '0;
    logic          arm = 1'b0;
    logic          force_nomatch = 1'b0;
    int            n_checks = 0;
    int            n_err = 0;

    gnr_attractor_sched #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
        .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos),
        .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
        .busy(busy), .done(done), .timeout(timeout), .meet_steps(meet_steps),
        .period(period), .attractor(attractor)
    );

    always #5 clk = ~clk;

    // Node array: s0 advances on every second start_s0 after a load, s1 on every start_s1.
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_q <= init_state;
            s1_q <= init_state;
            arm  <= 1'b1;
        end else begin
            if (start_s0) begin
                if (arm) s0_q <= ftab[s0_q];
                arm <= ~arm;
            end
            if (start_s1) s1_q <= ftab[s1_q];
        end
    end
    assign s0_vec = force_nomatch ? ~s1_q : s0_q;
    assign s1_vec = s1_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 16; i++) ftab[i] = N'(i);
    endtask

    task automatic set_rotate3();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            ftab[i] = {v[3], v[1:0], v[2]};
        end
    endtask

    // Reference: walk the orbit x_j = f^j(x0); meet is the first k >= 2 with x_k == x_ceil(k/2).
    task automatic ref_run(input logic [N-1:0] x0, input bit nomatch,
                           output int k, output bit to, output logic [N-1:0] attr, output int p);
        logic [N-1:0] xs [0:63];
        logic [N-1:0] y;
        xs[0] = x0;
        for (int j = 1; j < 64; j++) xs[j] = ftab[xs[j-1]];
        to = 1'b1; k = int'(MAXS); attr = '0; p = 0;
        for (int kk = 2; kk <= int'(MAXS); kk++) begin
            if (!nomatch && xs[kk] == xs[(kk + 1) / 2]) begin
                k = kk; to = 1'b0; attr = xs[kk];
                break;
            end
        end
        if (!to) begin
            y = ftab[attr]; p = 1;
            while (y != attr && p < 64) begin y = ftab[y]; p++; end
        end
    endtask

    task automatic do_run(input string tag, input logic [N-1:0] x0, input bit nomatch, input bit poke_busy);
        int k, p, c_rn, c0, c1, cyc, exp_cyc;
        bit to;
        logic [N-1:0] attr;
        force_nomatch = nomatch;
        ref_run(x0, nomatch, k, to, attr, p);
        @(negedge clk);
        init_vec = x0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_load_rn"}, 32'(reset_nos), 32'd1);
        check({tag, "_load_init"}, 32'(init_state), 32'(x0));
        check({tag, "_load_done"}, 32'(done), 32'd0);
        check({tag, "_load_busy"}, 32'(busy), 32'd1);
        c_rn = 0; c0 = 0; c1 = 0; cyc = 0;
        while (!done && cyc < 500) begin
            c_rn += int'(reset_nos);
            c0   += int'(start_s0);
            c1   += int'(start_s1);
            if (poke_busy && cyc == 3) begin
                start = 1'b1;
                init_vec = ~x0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        exp_cyc = 2 + k + ((PER_EN && !to) ? p + 1 : 0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'(to));
        check({tag, "_period"}, 32'(period), (PER_EN && !to) ? 32'(p) : 32'd0);
        check({tag, "_init_kept"}, 32'(init_state), 32'(x0));
        check({tag, "_n_load"}, 32'(c_rn), 32'd1);
        check({tag, "_n_s0"}, 32'(c0), 32'(k));
        check({tag, "_n_s1"}, 32'(c1), 32'(k + ((PER_EN && !to) ? p : 0)));
        if (!to) begin
            check({tag, "_meet"}, 32'(meet_steps), 32'(k));
            check({tag, "_attr"}, 32'(attractor), 32'(attr));
        end
        force_nomatch = 1'b0;
    endtask

    initial begin
        int guard;
        set_identity();
        repeat (3) @(negedge clk);
        check("rst_rn", 32'(reset_nos), 32'd0);
        check("rst_s0", 32'(start_s0), 32'd0);
        check("rst_s1", 32'(start_s1), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_meet", 32'(meet_steps), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_attr", 32'(attractor), 32'd0);
        check("rst_init", 32'(init_state), 32'd0);

        // Fixed point: meet at k = 2, period 1.
        do_run("ident", 4'b0101, 1'b0, 1'b0);

        // Rotate-3 oscillator with a start pulse while busy.
        set_rotate3();
        do_run("rot3", 4'b0001, 1'b0, 1'b1);

        // s0 path forced to never match: timeout at MAXS.
        do_run("tmo", 4'b0001, 1'b1, 1'b0);

        // Reset part-way through RUN.
        @(negedge clk);
        init_vec = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(start_s0 && dut.step_cnt == 16'd3) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_reach", 32'(guard < 100), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_s0", 32'(start_s0), 32'd0);
        check("midrst_s1", 32'(start_s1), 32'd0);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_init", 32'(init_state), 32'd0);
        check("midrst_rn", 32'(reset_nos), 32'd0);
        rst = 1'b1;
        do_run("rerun", 4'b0001, 1'b0, 1'b0);

        // Restart straight from DONE with a new vector.
        do_run("restart", 4'b0010, 1'b0, 1'b0);

        // Random next-state tables and initial states.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) ftab[i] = N'($urandom_range(0, 15));
            do_run($sformatf("rnd%0d", t), N'($urandom_range(0, 15)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
